// File: rtl/fft_frame_loader.sv
// fft_frame_loader
//
// Streaming front end for a 64-point FFT. Complex samples arrive one per
// valid/ready handshake and are packed into a parallel frame buffer that
// feeds the FFT's input_Re/input_Im arrays. When the last slot of the buffer
// is written, the loader issues a single-cycle start pulse. It then freezes
// the buffer and refuses input for HOLD_CYCLES cycles while the FFT computes.
//
// Parameters
//   N           samples per frame (power of two)
//   W           width of each sample component (two's complement, untouched)
//   HOLD_CYCLES cycles the frame is held stable after start (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears state and buffer
//   in_valid   sample present on in_re/in_im/in_last
//   in_ready   loader accepts a sample this cycle (FILL state, not in reset)
//   in_re      real part of the sample
//   in_im      imaginary part of the sample
//   in_last    marks the final sample of a frame
//   input_Re   frame buffer, real parts, to the FFT
//   input_Im   frame buffer, imaginary parts, to the FFT
//   start      one-cycle FFT launch pulse (registered)
//   busy       frame launched and being held (registered)
//   frame_err  one-cycle framing error pulse (registered)

module fft_frame_loader #(
  parameter int N           = 64,
  parameter int W           = 16,
  parameter int HOLD_CYCLES = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  input  logic         in_last,
  output logic [W-1:0] input_Re [N-1:0],
  output logic [W-1:0] input_Im [N-1:0],
  output logic         start,
  output logic         busy,
  output logic         frame_err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_nxt;
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_nxt;

  logic          w_accept;
  logic          w_frame_done;
  logic          w_err;
  logic          w_busy_nxt;

  logic          r_start;
  logic          r_busy;
  logic          r_frame_err;

  logic [W-1:0]  r_re [N-1:0];
  logic [W-1:0]  r_im [N-1:0];

  // in_ready is a pure decode of the state register; rst gates it so no
  // sample can be taken while the design is being cleared.
  assign in_ready = (r_state == ST_FILL) && !rst;
  assign w_accept = in_valid && in_ready;

  // Next-state, index and hold-counter logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_hold_nxt   = r_hold;
    w_frame_done = 1'b0;
    w_err        = 1'b0;

    unique case (r_state)
      ST_FILL: begin
        if (w_accept) begin
          if (r_idx == LAST_IDX) begin
            // Frame complete: launch regardless of in_last, but flag a
            // missing last marker.
            w_frame_done = 1'b1;
            w_err        = !in_last;
            w_idx_nxt    = '0;
            w_state_nxt  = ST_LAUNCH;
          end else if (in_last) begin
            // Early last: sample is kept, frame restarts at index 0 and
            // nothing is launched. Older entries stay until overwritten.
            w_err     = 1'b1;
            w_idx_nxt = '0;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end
      end

      ST_LAUNCH: begin
        // start is high during this single cycle; the hold counter is
        // loaded so HOLD lasts exactly HOLD_CYCLES cycles.
        w_hold_nxt  = HOLD_LOAD;
        w_state_nxt = ST_HOLD;
      end

      ST_HOLD: begin
        if (r_hold == '0) begin
          w_state_nxt = ST_FILL;
        end else begin
          w_hold_nxt = r_hold - HW'(1);
        end
      end

      default: begin
        w_state_nxt = ST_FILL;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_FILL);
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_FILL;
      r_idx       <= '0;
      r_hold      <= '0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_hold      <= w_hold_nxt;
      r_start     <= w_frame_done;
      r_busy      <= w_busy_nxt;
      r_frame_err <= w_err;
    end
  end

  // Frame buffer: written only on an accepted sample, so it is frozen in
  // LAUNCH and HOLD. Reset clears every entry so a stale frame can never be
  // launched after a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_re[i] <= '0;
        r_im[i] <= '0;
      end
    end else if (w_accept) begin
      r_re[r_idx] <= in_re;
      r_im[r_idx] <= in_im;
    end
  end

  assign input_Re  = r_re;
  assign input_Im  = r_im;
  assign start     = r_start;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_fft_frame_loader.sv
module tb_fft_frame_loader;
  localparam int N = 64;
  localparam int W = 16;
  localparam int H = 100;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_re;
  logic [W-1:0] in_im;
  logic         in_last;
  logic [W-1:0] dut_re [N-1:0];
  logic [W-1:0] dut_im [N-1:0];
  logic         start;
  logic         busy;
  logic         frame_err;

  fft_frame_loader #(.N(N), .W(W), .HOLD_CYCLES(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_re    (in_re),
    .in_im    (in_im),
    .in_last  (in_last),
    .input_Re (dut_re),
    .input_Im (dut_im),
    .start    (start),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed pulse cycles (sampled on the falling edge) and model predictions.
  int st_q[$];
  int er_q[$];
  int exp_st[$];
  int exp_er[$];

  always @(negedge clk) begin
    if (start === 1'b1) st_q.push_back(cyc);
    if (frame_err === 1'b1) er_q.push_back(cyc);
  end

  // Reference model: the frame as the spec describes it.
  logic [W-1:0] m_re [N];
  logic [W-1:0] m_im [N];
  int           m_idx;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_re[i] = '0;
      m_im[i] = '0;
    end
    m_idx = 0;
  endfunction

  // Accept at cycle k: pulses (if any) appear in cycle k+1.
  function automatic void model_accept(input logic [W-1:0] re, input logic [W-1:0] im,
                                       input logic last, input int k);
    m_re[m_idx] = re;
    m_im[m_idx] = im;
    if (m_idx == N - 1) begin
      exp_st.push_back(k + 1);
      if (!last) exp_er.push_back(k + 1);
      m_idx = 0;
    end else if (last) begin
      exp_er.push_back(k + 1);
      m_idx = 0;
    end else begin
      m_idx = m_idx + 1;
    end
  endfunction

  // Present one sample and wait (bounded) for it to be accepted.
  task automatic push(input logic [W-1:0] re, input logic [W-1:0] im, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    in_last  = last;
    while (in_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      chk("push_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    model_accept(re, im, last, cyc);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // mode 0: re=i, im=-i ; mode 1: random data. last_at < 0 means no in_last.
  task automatic send_frame(input int cnt, input int last_at, input int mode, input bit gaps);
    logic [W-1:0] re, im;
    for (int i = 0; i < cnt; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      if (mode == 0) begin
        re = W'(i);
        im = W'(-i);
      end else begin
        re = W'($urandom);
        im = W'($urandom);
      end
      push(re, im, (i == last_at));
    end
  endtask

  task automatic check_buf(input string tag);
    int bad = 0;
    for (int i = 0; i < N; i++)
      if (dut_re[i] !== m_re[i] || dut_im[i] !== m_im[i]) bad++;
    chk(tag, bad, 0);
  endtask

  // Called on the falling edge of the start cycle.
  task automatic hold_check(input string tag);
    logic [W-1:0] s_re [N];
    logic [W-1:0] s_im [N];
    int cnt = 0;
    int ch  = 0;
    for (int i = 0; i < N; i++) begin
      s_re[i] = dut_re[i];
      s_im[i] = dut_im[i];
    end
    for (int j = 0; j <= H; j++) begin
      if (busy === 1'b1 && in_ready === 1'b0) cnt++;
      for (int i = 0; i < N; i++)
        if (dut_re[i] !== s_re[i] || dut_im[i] !== s_im[i]) ch++;
      @(negedge clk);
    end
    chk({tag, "_hold_cycles"}, cnt, H + 1);
    chk({tag, "_frozen"}, ch, 0);
    chk({tag, "_ready_back"}, in_ready, 1);
    chk({tag, "_busy_drop"}, busy, 0);
  endtask

  task automatic cmp_events(input string tag);
    int bad = 0;
    @(negedge clk);
    #1;
    chk({tag, "_nstart"}, st_q.size(), exp_st.size());
    chk({tag, "_nerr"}, er_q.size(), exp_er.size());
    if (st_q.size() == exp_st.size())
      for (int i = 0; i < st_q.size(); i++) if (st_q[i] != exp_st[i]) bad++;
    if (er_q.size() == exp_er.size())
      for (int i = 0; i < er_q.size(); i++) if (er_q[i] != exp_er[i]) bad++;
    chk({tag, "_event_cycles"}, bad, 0);
    st_q.delete();
    er_q.delete();
    exp_st.delete();
    exp_er.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
    in_last  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    // Power-on reset state
    chk("rst_ready", in_ready, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", frame_err, 0);
    check_buf("rst_buf");
    rst = 1'b0;
    #1;
    chk("rel_ready", in_ready, 1);

    // Reset mid-stream after 10 accepts
    send_frame(10, -1, 1, 1'b0);
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_ready", in_ready, 0);
    chk("midrst_start", start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", frame_err, 0);
    check_buf("midrst_buf");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_rel_ready", in_ready, 1);
    cmp_events("rst");

    // Full frame, continuous valid, ramp data
    send_frame(N, N - 1, 0, 1'b0);
    chk("full_start_now", start, 1);
    chk("full_re5", dut_re[5], 5);
    check_buf("full_buf");
    hold_check("full");
    cmp_events("full");

    // Throttled source, same data
    send_frame(N, N - 1, 0, 1'b1);
    check_buf("thr_buf");
    hold_check("thr");
    cmp_events("thr");

    // Backpressure during HOLD
    send_frame(N, N - 1, 1, 1'b0);
    check_buf("bp_buf_pre");
    in_valid = 1'b1;
    in_re    = 16'h1234;
    in_im    = 16'h4321;
    in_last  = 1'b0;
    hold_check("bp");
    model_accept(16'h1234, 16'h4321, 1'b0, cyc);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_entry0", dut_re[0], 16'h1234);
    check_buf("bp_buf_post");
    send_frame(N - 1, N - 2, 1, 1'b0);
    hold_check("bp2");
    cmp_events("bp");

    // Early last on sample 9, then a clean frame
    send_frame(10, 9, 1, 1'b0);
    chk("early_busy", busy, 0);
    chk("early_ready", in_ready, 1);
    check_buf("early_buf");
    cmp_events("early");
    send_frame(N, N - 1, 1, 1'b0);
    check_buf("after_early_buf");
    hold_check("after_early");
    cmp_events("after_early");

    // Missing last
    send_frame(N, -1, 1, 1'b0);
    check_buf("miss_buf");
    hold_check("miss");
    chk("miss_same_cycle",
        (st_q.size() > 0 && er_q.size() > 0) ? longint'(st_q[0] == er_q[0]) : 0, 1);
    cmp_events("miss");

    // Back-to-back frames
    send_frame(N, N - 1, 1, 1'b0);
    send_frame(N, N - 1, 1, 1'b0);
    check_buf("b2b_buf");
    hold_check("b2b");
    chk("b2b_period", (st_q.size() == 2) ? longint'(st_q[1] - st_q[0]) : -1, N + H + 1);
    cmp_events("b2b");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
